alu_req_arbiter: RTL and testbench

Two-port request controller that shares one combinational 7-bit ALU between two independent requesters. It accepts {A, B, OP} transactions over valid/ready handshakes, arbitrates round-robin, drives registered operands and opcode into the ALU, captures Result and the C/V/N/Z flags, and returns them on a per-requester response channel with backpressure. It sits between the datapath's command sources and the ALU instance; OP is forwarded unchanged as the ALU's 4-bit {shift[3:2], op[1:0]} code.

---
 rtl/alu_ctrl_pkg.sv | 30 +++
 rtl/alu_req_arbiter_rr_arb2.sv | 36 +++
 rtl/alu_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-port ALU request controller.
package alu_ctrl_pkg;

  localparam int ALU_W   = 7;   // operand/result width
  localparam int ALU_OPW = 4;   // {shift[3:2], op[1:0]}
  localparam int FLAGS_W = 4;   // {C,V,N,Z}
  localparam int CNT_W   = 8;   // issue counter width

  // Flag bit positions inside the packed flag vector.
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Identifies which requester owns the in-flight transaction.
  typedef logic req_id_t;

  // Saturating increment used by the per-port issue counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the valids and the
// priority pointer; the pointer moves to the loser whenever a grant is taken.
module rr_arb2
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output req_id_t    winner,
  output req_id_t    ptr
);

  // One valid wins outright; with both valid the pointer picks the winner.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

  assign winner = grant[1];

  // Priority pointer: after a taken grant, favour the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~winner;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-port request controller sharing one combinational ALU.
//
// Handshake rule for every channel here: a transfer happens on a rising clock
// edge where valid and ready are both high; the sender keeps valid and payload
// stable until that edge. reqN_ready depends only on state, the request valids
// and the priority pointer; rspN_valid depends only on state and owner.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [W-1:0]       req0_a,
  input  logic [W-1:0]       req0_b,
  input  logic [OPW-1:0]     req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [W-1:0]       req1_a,
  input  logic [W-1:0]       req1_b,
  input  logic [OPW-1:0]     req1_op,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [W-1:0]       rsp0_result,
  output logic [FLAGS_W-1:0] rsp0_flags,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [W-1:0]       rsp1_result,
  output logic [FLAGS_W-1:0] rsp1_flags,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [W-1:0]       alu_result,
  input  logic               alu_c,
  input  logic               alu_v,
  input  logic               alu_n,
  input  logic               alu_z,
  output logic               busy,
  output logic [CNT_W-1:0]   issue_cnt0,
  output logic [CNT_W-1:0]   issue_cnt1,
  output state_t             state_dbg
);

  state_t             state_q, state_d;
  logic [1:0]         grant;
  req_id_t            winner;
  req_id_t            ptr;
  req_id_t            owner_q;
  logic               accept;
  logic               rsp_fire;
  logic [W-1:0]       rsp_result_q;
  logic [FLAGS_W-1:0] rsp_flags_q;
  logic [FLAGS_W-1:0] alu_flags;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant),
    .winner  (winner),
    .ptr     (ptr)
  );

  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  // grant is a subset of the valids, so a non-zero grant in IDLE is a transfer.
  assign accept     = (state_q == IDLE) && (grant != 2'b00);
  assign rsp_fire   = owner_q ? rsp1_ready : rsp0_ready;

  assign rsp0_valid  = (state_q == RESP) && (owner_q == 1'b0);
  assign rsp1_valid  = (state_q == RESP) && (owner_q == 1'b1);
  // One capture register serves both ports; only the owner's valid is raised.
  assign rsp0_result = rsp_result_q;
  assign rsp1_result = rsp_result_q;
  assign rsp0_flags  = rsp_flags_q;
  assign rsp1_flags  = rsp_flags_q;

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // Pack the ALU flags into the shared {C,V,N,Z} layout.
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_Z] = alu_z;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept -> one settle cycle -> hold response until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU input registers: only change on accept so the ALU never sees glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      owner_q <= 1'b0;
    end else if (accept) begin
      owner_q <= winner;
      alu_a   <= winner ? req1_a  : req0_a;
      alu_b   <= winner ? req1_b  : req0_b;
      alu_op  <= winner ? req1_op : req0_op;
    end
  end

  // Response capture at the end of the settle cycle; held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else if (state_q == EXEC) begin
      rsp_result_q <= alu_result;
      rsp_flags_q  <= alu_flags;
    end
  end

  // Per-requester saturating count of accepted transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt0 <= '0;
      issue_cnt1 <= '0;
    end else if (accept) begin
      if (winner) issue_cnt1 <= sat_inc(issue_cnt1);
      else        issue_cnt0 <= sat_inc(issue_cnt0);
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU, requester driver tasks,
// per-port expected-response queues and a final summary.
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  localparam int W   = 7;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic           rsp0_valid, rsp1_valid;
  logic           rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0]   rsp0_result, rsp1_result;
  logic [3:0]     rsp0_flags, rsp1_flags;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [OPW-1:0] alu_op;
  logic           alu_c, alu_v, alu_n, alu_z;
  logic           busy;
  logic [7:0]     issue_cnt0, issue_cnt1;
  state_t         state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+3:0] exp_q0[$];
  logic [W+3:0] exp_q1[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model: op 0 add, 1 sub, 2 and, 3 or; shift 1 shl, 2 shr
  function automatic logic [W+3:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OPW-1:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op[1:0])
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 8'd1;
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    case (op[3:2])
      2'd1: r = {r[W-2:0], 1'b0};
      2'd2: r = {1'b0, r[W-1:1]};
      default: ;
    endcase
    return {r, c, v, r[W-1], (r == '0)};
  endfunction

  assign {alu_result, alu_c, alu_v, alu_n, alu_z} = alu_model(alu_a, alu_b, alu_op);

  alu_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .busy(busy), .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard: push on accept, pop on response ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) exp_q0.push_back(alu_model(req0_a, req0_b, req0_op));
      if (req1_valid && req1_ready) exp_q1.push_back(alu_model(req1_a, req1_b, req1_op));
      if (rsp0_valid && rsp0_ready) begin
        n_checks++;
        if (exp_q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb_rsp0_unexpected got=%h", {rsp0_result, rsp0_flags});
        end else begin
          logic [W+3:0] e0;
          e0 = exp_q0.pop_front();
          if ({rsp0_result, rsp0_flags} !== e0) begin
            n_fail++;
            $display("FAIL sb_rsp0 got=%h exp=%h", {rsp0_result, rsp0_flags}, e0);
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        n_checks++;
        if (exp_q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb_rsp1_unexpected got=%h", {rsp1_result, rsp1_flags});
        end else begin
          logic [W+3:0] e1;
          e1 = exp_q1.pop_front();
          if ({rsp1_result, rsp1_flags} !== e1) begin
            n_fail++;
            $display("FAIL sb_rsp1 got=%h exp=%h", {rsp1_result, rsp1_flags}, e1);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (busy || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout busy=%0b q0=%0d q1=%0d required idle/empty", busy, exp_q0.size(), exp_q1.size());
    end
  endtask

  // Issue one transaction and return the response seen at its handshake.
  task automatic send(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [OPW-1:0] op, output logic [W-1:0] res, output logic [3:0] fl);
    int   t;
    logic got;
    res = '0; fl = '0;
    @(posedge clk); #1;
    if (port == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else           begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    got = 1'b0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) got = 1'b1; else t++;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL send_accept_timeout port=%0d", port); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    got = 1'b0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (port == 0 && rsp0_valid && rsp0_ready) begin got = 1'b1; res = rsp0_result; fl = rsp0_flags; end
      else if (port == 1 && rsp1_valid && rsp1_ready) begin got = 1'b1; res = rsp1_result; fl = rsp1_flags; end
      else t++;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL send_rsp_timeout port=%0d", port); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 ||
        alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || rsp0_result !== '0 || rsp1_result !== '0 ||
        rsp0_flags !== '0 || rsp1_flags !== '0 || issue_cnt0 !== 8'h00 || issue_cnt1 !== 8'h00 ||
        state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b%b vld=%b%b busy=%b alu=%h/%h/%h res=%h/%h cnt=%h/%h required all zero",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_a, alu_b, alu_op,
               rsp0_result, rsp1_result, issue_cnt0, issue_cnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 7'h05; req0_b = 7'h03; req0_op = 4'h0;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready got=%b%b required 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== EXEC || busy !== 1'b1 || rsp0_valid !== 1'b0 || alu_a !== 7'h05 || alu_b !== 7'h03) begin
      n_fail++; $display("FAIL single_exec got st=%0d busy=%b v=%b a=%h b=%h required EXEC,1,0,05,03",
                         state_dbg, busy, rsp0_valid, alu_a, alu_b);
    end
    @(negedge clk);
    n_checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== 7'h08 || rsp0_flags !== 4'b0000) begin
      n_fail++; $display("FAIL single_rsp got v=%b%b res=%h fl=%b required 10 08 0000",
                         rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags);
    end
    wait_idle();
  endtask

  task automatic test_flags();
    logic [W-1:0] r;
    logic [3:0]   f;
    send(0, 7'h3F, 7'h01, 4'h0, r, f);
    n_checks++;
    if (r !== 7'h40 || f[FLAG_V] !== 1'b1 || f[FLAG_N] !== 1'b1 || f[FLAG_Z] !== 1'b0) begin
      n_fail++; $display("FAIL flags_add_ovf got res=%h fl=%b required 40 with V=1 N=1 Z=0", r, f);
    end
    send(1, 7'h2A, 7'h2A, 4'h1, r, f);
    n_checks++;
    if (r !== 7'h00 || f[FLAG_Z] !== 1'b1 || f[FLAG_N] !== 1'b0) begin
      n_fail++; $display("FAIL flags_sub_zero got res=%h fl=%b required 00 with Z=1 N=0", r, f);
    end
    send(0, 7'h51, 7'h24, 4'h7, r, f);
    n_checks++;
    if (r !== 7'h6A) begin
      n_fail++; $display("FAIL flags_or_shl got res=%h required 6a", r);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [W+3:0] e;
    int           t;
    rsp1_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 7'h33; req1_b = 7'h19; req1_op = 4'h1;
    e = alu_model(7'h33, 7'h19, 4'h1);
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req1_ready got=%b required 1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = $urandom_range(0, 127); req0_b = $urandom_range(0, 127); req0_op = $urandom_range(0, 15);
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp1_valid && t < 10);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp1_valid !== 1'b1 || {rsp1_result, rsp1_flags} !== e || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b rsp=%h r0rdy=%b required v=1 rsp=%h r0rdy=0",
                           i, rsp1_valid, {rsp1_result, rsp1_flags}, req0_ready, e);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_early got=%b required 0", req0_ready); end
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_resume got r0rdy=%b v1=%b required 1 0", req0_ready, rsp1_valid);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_contention();
    int   order[$];
    int   cyc;
    logic hs0, hs1;
    apply_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = $urandom_range(0, 127); req0_b = $urandom_range(0, 127); req0_op = $urandom_range(0, 15);
    req1_valid = 1'b1; req1_a = $urandom_range(0, 127); req1_b = $urandom_range(0, 127); req1_op = $urandom_range(0, 15);
    cyc = 0;
    while (order.size() < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0) order.push_back(0);
      if (hs1) order.push_back(1);
      @(posedge clk); #1;
      if (hs0) begin req0_a = $urandom_range(0, 127); req0_b = $urandom_range(0, 127); req0_op = $urandom_range(0, 15); end
      if (hs1) begin req1_a = $urandom_range(0, 127); req1_b = $urandom_range(0, 127); req1_op = $urandom_range(0, 15); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (order.size() != 12) begin n_fail++; $display("FAIL rr_count got=%0d required 12", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      n_checks++;
      if (order[k] !== (k % 2)) begin n_fail++; $display("FAIL rr_order idx=%0d got=%0d required=%0d", k, order[k], k % 2); end
    end
    wait_idle();
    n_checks++;
    if (issue_cnt0 !== 8'd6 || issue_cnt1 !== 8'd6) begin
      n_fail++; $display("FAIL rr_issue_cnt got=%0d/%0d required 6/6", issue_cnt0, issue_cnt1);
    end
  endtask

  task automatic test_reset_in_resp();
    int   t;
    logic seen;
    rsp0_ready = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 7'h12; req0_b = 7'h34; req0_op = 4'h2;
    t = 0;
    do begin @(negedge clk); t++; end while (!req0_ready && t < 10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp0_valid && t < 10);
    n_checks++;
    if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL rir_reach_resp got=%b required 1", rsp0_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE || alu_a !== '0 || alu_op !== '0 ||
        rsp0_result !== '0 || rsp0_flags !== '0 || issue_cnt0 !== 8'h00 || issue_cnt1 !== 8'h00) begin
      n_fail++; $display("FAIL rir_async_clear got v=%b busy=%b st=%0d a=%h res=%h fl=%b cnt=%h/%h required zeros",
                         rsp0_valid, busy, state_dbg, alu_a, rsp0_result, rsp0_flags, issue_cnt0, issue_cnt1);
    end
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rir_no_response got activity=%b required 0", seen); end
  endtask

  task automatic test_saturation();
    int         acc, cyc;
    logic [7:0] exp_cnt;
    apply_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = $urandom_range(0, 127); req0_b = $urandom_range(0, 127); req0_op = $urandom_range(0, 15);
    acc = 0; cyc = 0;
    while (acc < 260 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (req0_valid && req0_ready) begin
        acc++;
        if (acc == 1 || acc == 101 || acc == 256 || acc == 258 || acc == 260) begin
          exp_cnt = (acc - 1 > 255) ? 8'hFF : 8'(acc - 1);
          n_checks++;
          if (issue_cnt0 !== exp_cnt) begin
            n_fail++; $display("FAIL sat_cnt accept=%0d got=%h required=%h", acc, issue_cnt0, exp_cnt);
          end
        end
        @(posedge clk); #1;
        req0_a = $urandom_range(0, 127); req0_b = $urandom_range(0, 127); req0_op = $urandom_range(0, 15);
        if (acc == 260) req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (acc != 260 || issue_cnt0 !== 8'hFF || issue_cnt1 !== 8'h00) begin
      n_fail++; $display("FAIL sat_final got acc=%0d cnt=%h/%h required 260 ff/00", acc, issue_cnt0, issue_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_contention();
    test_reset_in_resp();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
